// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: tracks pending lines (edge or level per line) and
// presents one request at a time to the ID stage, holding it until the core acknowledges.
module irq_arbiter #(
    parameter int unsigned          NUM_IRQ   = 16,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               global_ie,
    input  logic               irq_ack,
    output logic               irq_req,
    output logic [4:0]         irq_id,
    output logic [NUM_IRQ-1:0] irq_pending
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_IRQ-1:0] src_q;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clear;
    logic [4:0]         winner;
    logic [4:0]         id_nxt;
    logic               any_eligible;
    logic               found;
    logic               ack_valid;

    // An ack only means something while a request is actually being presented.
    assign ack_valid = (state == S_REQ) && irq_ack;

    always_comb begin
        ack_clear = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            ack_clear[i] = ack_valid && (irq_id == 5'(i));
        end
    end

    // Edge lines: a new rising edge beats a simultaneous ack clear.
    always_comb begin
        pending_nxt = irq_pending;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                if (irq_src[i] && !src_q[i]) begin
                    pending_nxt[i] = 1'b1;
                end else if (ack_clear[i]) begin
                    pending_nxt[i] = 1'b0;
                end
            end else begin
                pending_nxt[i] = irq_src[i];
            end
        end
    end

    always_comb begin
        eligible     = global_ie ? (irq_pending & irq_en) : '0;
        any_eligible = |eligible;
        winner       = '0;
        found        = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && !found) begin
                winner = 5'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = irq_id;
        unique case (state)
            S_IDLE: begin
                if (any_eligible) begin
                    state_nxt = S_REQ;
                    id_nxt    = winner;
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            irq_req     <= 1'b0;
            irq_id      <= '0;
            irq_pending <= '0;
            src_q       <= '0;
        end else begin
            state       <= state_nxt;
            irq_req     <= (state_nxt == S_REQ);
            irq_id      <= id_nxt;
            irq_pending <= pending_nxt;
            src_q       <= irq_src;
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed scenarios followed by random traffic, all checked every cycle against a
// cycle-level reference model of pending bits and request/blackout behaviour.
module tb_irq_arbiter;

    localparam int             N     = 16;
    localparam logic [N-1:0]   EMASK = 16'h00FE;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  irq_src;
    logic [N-1:0]  irq_en;
    logic          global_ie;
    logic          irq_ack;
    logic          irq_req;
    logic [4:0]    irq_id;
    logic [N-1:0]  irq_pending;

    int n_checks = 0;
    int n_fails  = 0;

    logic [N-1:0] m_pend;
    logic [N-1:0] m_srcq;
    logic         m_req;
    int           m_id;
    int           m_blackout;

    irq_arbiter #(.NUM_IRQ(N), .EDGE_MASK(EMASK)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_src    (irq_src),
        .irq_en     (irq_en),
        .global_ie  (global_ie),
        .irq_ack    (irq_ack),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        int r = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic model_update();
        logic [N-1:0] nxt;
        if (!reset_n) begin
            m_pend     = '0;
            m_srcq     = '0;
            m_req      = 1'b0;
            m_id       = 0;
            m_blackout = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (EMASK[i]) begin
                    if (irq_src[i] && !m_srcq[i]) nxt[i] = 1'b1;
                    else if (m_req && irq_ack && m_id == i) nxt[i] = 1'b0;
                    else nxt[i] = m_pend[i];
                end else begin
                    nxt[i] = irq_src[i];
                end
            end
            if (m_req) begin
                if (irq_ack) begin
                    m_req      = 1'b0;
                    m_blackout = 1;
                end
            end else if (m_blackout > 0) begin
                m_blackout--;
            end else if (global_ie && (m_pend & irq_en) != '0) begin
                m_req = 1'b1;
                m_id  = lowest(m_pend & irq_en);
            end
            m_pend = nxt;
            m_srcq = irq_src;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("model_req", {31'd0, irq_req}, {31'd0, m_req});
        chk("model_pending", {16'd0, irq_pending}, {16'd0, m_pend});
        if (m_req) chk("model_id", {27'd0, irq_id}, m_id);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        irq_src   = '0;
        irq_en    = '1;
        global_ie = 1'b1;
        irq_ack   = 1'b0;
        run(2);
        chk("rst_req", {31'd0, irq_req}, 0);
        chk("rst_id", {27'd0, irq_id}, 0);
        chk("rst_pend", {16'd0, irq_pending}, 0);
        reset_n = 1'b1;
        run(3);

        // edge line 3: pending one cycle after the edge, request one cycle later
        irq_src[3] = 1'b1;
        step();
        chk("t1_pend3", {31'd0, irq_pending[3]}, 1);
        chk("t1_req_early", {31'd0, irq_req}, 0);
        irq_src[3] = 1'b0;
        step();
        chk("t1_req", {31'd0, irq_req}, 1);
        chk("t1_id", {27'd0, irq_id}, 3);
        run(2);
        pulse_ack();
        chk("t1_ack_req", {31'd0, irq_req}, 0);
        chk("t1_ack_pend3", {31'd0, irq_pending[3]}, 0);
        run(3);

        // lines 5 and 2 together: 2 first, then 5 after two idle cycles
        irq_src[5] = 1'b1;
        irq_src[2] = 1'b1;
        step();
        irq_src = '0;
        step();
        chk("t2_id_first", {27'd0, irq_id}, 2);
        pulse_ack();
        chk("t2_gap0", {31'd0, irq_req}, 0);
        step();
        chk("t2_gap1", {31'd0, irq_req}, 0);
        step();
        chk("t2_req_second", {31'd0, irq_req}, 1);
        chk("t2_id_second", {27'd0, irq_id}, 5);
        pulse_ack();
        run(3);

        // request for 7 held while line 1 arrives and gie drops
        irq_src[7] = 1'b1;
        step();
        irq_src[7] = 1'b0;
        step();
        chk("t3_id7", {27'd0, irq_id}, 7);
        irq_src[1] = 1'b1;
        global_ie  = 1'b0;
        step();
        irq_src[1] = 1'b0;
        run(3);
        chk("t3_hold_req", {31'd0, irq_req}, 1);
        chk("t3_hold_id", {27'd0, irq_id}, 7);
        pulse_ack();
        run(4);
        chk("t3_gie_off", {31'd0, irq_req}, 0);
        global_ie = 1'b1;
        step();
        chk("t3_gie_on_req", {31'd0, irq_req}, 1);
        chk("t3_gie_on_id", {27'd0, irq_id}, 1);
        pulse_ack();
        run(3);

        // new edge on line 4 in the ack cycle keeps it pending
        irq_src[4] = 1'b1;
        step();
        step();
        irq_src[4] = 1'b0;
        step();
        chk("t4_id4", {27'd0, irq_id}, 4);
        irq_src[4] = 1'b1;
        pulse_ack();
        chk("t4_pend_kept", {31'd0, irq_pending[4]}, 1);
        irq_src[4] = 1'b0;
        step();
        chk("t4_gap", {31'd0, irq_req}, 0);
        step();
        chk("t4_rereq", {31'd0, irq_req}, 1);
        chk("t4_reid", {27'd0, irq_id}, 4);
        pulse_ack();
        run(3);

        // level line 0 held high: re-presented every three cycles
        irq_src[0] = 1'b1;
        run(2);
        chk("t5_first", {27'd0, irq_id}, 0);
        for (int r = 0; r < 3; r++) begin
            pulse_ack();
            chk("t5_off0", {31'd0, irq_req}, 0);
            step();
            chk("t5_off1", {31'd0, irq_req}, 0);
            step();
            chk("t5_again", {31'd0, irq_req}, 1);
        end
        irq_src[0] = 1'b0;
        pulse_ack();
        run(4);
        chk("t5_stopped", {31'd0, irq_req}, 0);
        chk("t5_pend", {16'd0, irq_pending}, 0);

        // reset while requesting, then a stray ack
        irq_src[6] = 1'b1;
        step();
        irq_src[6] = 1'b0;
        step();
        chk("t6_req", {31'd0, irq_req}, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_rst_req", {31'd0, irq_req}, 0);
        chk("t6_rst_pend", {16'd0, irq_pending}, 0);
        chk("t6_rst_id", {27'd0, irq_id}, 0);
        pulse_ack();
        chk("t6_stray_req", {31'd0, irq_req}, 0);
        run(2);
        chk("t6_quiet", {31'd0, irq_req}, 0);

        for (int c = 0; c < 3000; c++) begin
            irq_src   = 16'($urandom) & 16'($urandom);
            irq_en    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : '1;
            global_ie = ($urandom_range(0, 7) != 0);
            irq_ack   = ($urandom_range(0, 2) == 0);
            reset_n   = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
